// File: rtl/muldiv_unit_if.sv
// Handshake and register-file-side bundle between the MIPS core and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Magnitudes are processed unsigned; signs are fixed up in a final cycle.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;       // {hi half / remainder, lo half / quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign signed_op = ~bus.op[0];
  assign a_sgn     = signed_op & bus.a[WIDTH-1];
  assign b_sgn     = signed_op & bus.b[WIDTH-1];
  assign a_abs     = a_sgn ? -bus.a : bus.a;
  assign b_abs     = b_sgn ? -bus.b : bus.b;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

  // Divide step: shift the next dividend bit into the partial remainder and
  // trial-subtract; a borrow in the top bit means restore.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod_fix  = neg_q ? -acc : acc;
  assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // Divide by zero yields all-ones quotient; the remainder path already
  // returns the signed dividend because every trial subtract of zero succeeds.
  assign quo_fix   = (opnd == '0) ? '1 :
                     (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CALC;
      S_CALC: begin
        if (bus.abort)     state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            is_div <= bus.op[1];
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn & bus.op[1];
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_abs};
              opnd <= b_abs;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_abs};
              opnd <= a_abs;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div)
            acc <= {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                    acc[WIDTH-2:0], ~div_diff[WIDTH]};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // HI/LO: an operation result wins in the FIX cycle; MTHI/MTLO only land
  // while idle, so writes issued during an operation are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == S_FIX && !bus.abort) begin
        done_q <= 1'b1;
        if (is_div) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
      end else if (state == S_IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a cycle-level reference model checked every
// cycle, plus literal expectations for the headline vectors.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the arithmetic rules.
  function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    int          sa;
    int          sb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin ps = longint'(sa) * longint'(sb); h = ps[63:32]; l = ps[31:0]; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; h = pu[63:32]; l = pu[31:0]; end
      2'b10: begin
        if (b == 0)                                  begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == '1)      begin h = '0; l = a; end
        else                                         begin h = sa % sb; l = sa / sb; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else        begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Cycle-level reference: remaining busy cycles plus the pending result.
  int           m_rem;
  logic         m_done;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem != 0) begin
        if (bus.abort) m_rem = 0;
        else if (m_rem == 1) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
          m_rem  = 0;
        end else m_rem--;
      end else begin
        if (bus.start) begin
          model_op(bus.op, bus.a, bus.b, p_hi, p_lo);
          m_rem = W + 1;
        end
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("busy", W'(bus.busy), W'(m_rem != 0));
      check("done", W'(bus.done), W'(m_done));
      check("hi",   bus.hi, m_hi);
      check("lo",   bus.lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called right after start_op; returns one time unit into the done cycle.
  task automatic wait_done(input string name);
    int k  = 0;
    int nb = bus.busy ? 1 : 0;
    while (!bus.done && k < 100) begin
      tick();
      k++;
      if (bus.busy) nb++;
    end
    check({name, " latency"}, W'(k), W'(W + 1));
    check({name, " busy cycles"}, W'(nb), W'(W + 1));
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    start_op(op, a, b);
    wait_done(name);
    check({name, " hi"}, bus.hi, eh);
    check({name, " lo"}, bus.lo, el);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.abort = 1'b0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    #12;
    check("reset busy", W'(bus.busy), '0);
    check("reset done", W'(bus.done), '0);
    check("reset hi", bus.hi, '0);
    check("reset lo", bus.lo, '0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div -5/0",  2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu 7/0",  2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Abort mid-divide with an ignored start pulse along the way.
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort busy", W'(bus.busy), '0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done) seen++;
    end
    check("abort no done", W'(seen), '0);
    check("abort hi", bus.hi, 32'h0000_0000);
    check("abort lo", bus.lo, 32'h8000_0000);

    // Abort together with start in IDLE: start wins.
    bus.abort = 1'b1;
    start_op(2'b11, 32'd100, 32'd7);
    bus.abort = 1'b0;
    check("idle abort+start busy", W'(bus.busy), 32'd1);
    wait_done("divu 100/7");
    check("divu 100/7 hi", bus.hi, 32'd2);
    check("divu 100/7 lo", bus.lo, 32'd14);

    // MTHI alone, then MTHI+MTLO together.
    tick();
    bus.wdata = 32'h1234_5678; bus.hi_we = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    check("mthi hi", bus.hi, 32'h1234_5678);
    check("mthi lo kept", bus.lo, 32'd14);
    bus.wdata = 32'hCAFE_F00D; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt both hi", bus.hi, 32'hCAFE_F00D);
    check("mt both lo", bus.lo, 32'hCAFE_F00D);

    // Writes held through the whole operation, FIX cycle included, are dropped.
    start_op(2'b01, 32'd3, 32'd4);
    bus.wdata = 32'hDEAD_BEEF; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    wait_done("multu 3*4");
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("multu 3*4 hi", bus.hi, 32'd0);
    check("multu 3*4 lo", bus.lo, 32'd12);

    // Back-to-back start issued in the done cycle.
    run_op("b2b multu 5*5", 2'b01, 32'd5, 32'd5, 32'd0, 32'd25);

    // Asynchronous reset mid-operation, released before the next clock edge.
    start_op(2'b01, 32'h0001_2345, 32'h0000_6789);
    repeat (14) tick();
    #1 rst_n = 1'b0;
    #1;
    check("rst busy", W'(bus.busy), '0);
    check("rst done", W'(bus.done), '0);
    check("rst hi", bus.hi, '0);
    check("rst lo", bus.lo, '0);
    #1 rst_n = 1'b1;
    tick();
    run_op("multu 6*7", 2'b01, 32'd6, 32'd7, 32'd0, 32'h0000_002A);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Adds MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO support to the MIPS core.
- Parametrised in datapath width. Radix-2, one bit per cycle; the core stalls on busy.
- Sits beside the ALU. Operands come from regfile read ports rs and rt. hi/lo feed the write-back mux.

Parameters:
- WIDTH, 32: operand, HI and LO width. Must be at least 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- abort  in  1  kill the operation in flight (pipeline flush).
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: hi/lo have just been updated by an operation.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand registers=0.
- States:
  - IDLE: on start=1 latch op. Latch |a| and |b| for signed ops, raw a and b for unsigned. Record result signs. Go to CALC; busy=1 from the next cycle.
  - CALC: exactly WIDTH cycles, one iteration per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract giving WIDTH-bit quotient and remainder.
  - FIX: one cycle. Apply sign correction, write hi/lo, return to IDLE.
    - busy=0 and done=1 for exactly the cycle after the FIX edge.
- Latency: start sampled at edge N → hi/lo written at edge N+WIDTH+1 → done high during cycle N+WIDTH+1..N+WIDTH+2. busy is high for WIDTH+1 cycles.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- start while busy=1: ignored; no queueing.
- Signed multiply: 2*WIDTH product negated (two's complement) when sign(a) xor sign(b).
- Signed divide:
  - Quotient negated when sign(a) xor sign(b).
  - Remainder takes the sign of the dividend.
  - Truncation toward zero.
- Divide by zero (b=0, signed or unsigned): lo = all ones, hi = a unchanged. Still takes the full WIDTH+1 cycles.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0.
- abort=1 while busy: next edge returns to IDLE, busy=0, no done, hi/lo unchanged. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort has no effect and start is accepted.
- hi_we/lo_we while IDLE: hi/lo take wdata at the edge; visible next cycle. Both may be written together.
- hi_we/lo_we while busy: ignored; the core never issues MTHI/MTLO while busy.
- done has priority: a hi_we/lo_we in the FIX cycle is dropped.
- hi/lo are stable between writes. Reads (MFHI/MFLO) are combinational from the registers.
- Reset asserted mid-operation: immediate IDLE, outputs to reset values; the operation is lost.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF → done 33 cycles after the start edge; hi=FFFFFFFE, lo=00000001; busy high 33 cycles.
- MULT a=FFFFFFFD (-3), b=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. Then DIV a=FFFFFFF9 (-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=0 → lo=FFFFFFFF, hi=00000007. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- Start DIVU 100/7; pulse start (MULTU 2*3) at cycle 10 while busy; abort at cycle 20 → busy drops next cycle, no done, hi/lo keep the prior values. A second start is then accepted from IDLE.
- In IDLE, hi_we with wdata=12345678 → hi=12345678 next cycle. lo_we during busy → lo unchanged. Start asserted on the done cycle → accepted; second done 33 cycles later.
- rst_n low at cycle 15 of a MULTU, released asynchronously mid-cycle → busy=0, done=0, hi=lo=0 immediately. A new MULTU 6*7 then gives lo=0000002A, hi=0.
